// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the npc instruction fetch unit.
// Holds the fetch FSM encoding, the reset PC default and the canonical NOP.
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StWait  = 3'd2,
    StIssue = 3'd3,
    StHalt  = 3'd4
  } ifu_state_e;

  localparam logic [31:0] ResetPcDefault = 32'h8000_0000;
  localparam logic [31:0] InstNop        = 32'h0000_0013;

  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;
  localparam logic [6:0] OpcodeJal    = 7'b1101111;
  localparam logic [6:0] OpcodeJalr   = 7'b1100111;

  // Instruction memory only takes word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fetch_reg.sv
// Generic write-enabled register with asynchronous active-low reset.
// Instantiated by the fetch unit to hold the PC.
module ifu_fetch_reg #(
  parameter int unsigned     Width    = 32,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= ResetVal;
    end else if (we_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one word read at a time and hands
// each fetched instruction to decode; squashes in-flight responses on redirect.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_we;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        squash_q, squash_d;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = word_align(redirect_pc);

  ifu_fetch_reg #(
    .Width    (32),
    .ResetVal (RESET_PC)
  ) u_pc_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (pc_we),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  always_comb begin
    state_d        = state_q;
    pc_we          = 1'b0;
    pc_d           = pc_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    squash_d       = squash_q;
    imem_req_valid = 1'b0;
    imem_req_addr  = 32'd0;
    inst_valid     = 1'b0;
    halted         = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req_valid = 1'b1;
        imem_req_addr  = pc_q;
        // Halt wins over both redirect and a same-cycle request acceptance.
        if (halt) begin
          state_d = StHalt;
        end else begin
          if (redirect_valid) begin
            pc_we = 1'b1;
            pc_d  = redirect_tgt;
          end
          if (imem_req_ready) begin
            state_d  = StWait;
            squash_d = redirect_valid;
          end
        end
      end
      StWait: begin
        if (redirect_valid) begin
          pc_we = 1'b1;
          pc_d  = redirect_tgt;
        end
        if (imem_rsp_valid) begin
          if (squash_q || redirect_valid) begin
            squash_d = 1'b0;
            state_d  = StFetch;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = StIssue;
          end
        end else if (redirect_valid) begin
          squash_d = 1'b1;
        end
      end
      StIssue: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          pc_we   = 1'b1;
          pc_d    = redirect_valid ? redirect_tgt : pc_q + 32'd4;
          state_d = halt ? StHalt : StFetch;
        end else if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_d    = redirect_tgt;
          state_d = StFetch;
        end
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
      squash_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      squash_q  <= squash_d;
    end
  end

  assign inst    = inst_q;
  assign inst_pc = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios then randomized traffic, all checked
// against a transaction-level model of fetch behaviour.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt = 1'b0;
  logic        halted;

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what the unit is doing, in transaction terms.
  logic [31:0] m_pc;
  bit          m_started;      // first idle cycle after reset has elapsed
  bit          m_outstanding;  // a request was accepted, response not yet seen
  bit          m_drop;         // the outstanding response must be thrown away
  bit          m_have;         // an instruction is being offered to decode
  bit          m_halted;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;

  bit          auto_mem = 1'b0;
  bit          mem_pend = 1'b0;
  logic [31:0] auto_data = 32'h0000_0013;

  task automatic model_reset();
    m_pc = 32'h8000_0000;
    m_started = 1'b0;
    m_outstanding = 1'b0;
    m_drop = 1'b0;
    m_have = 1'b0;
    m_halted = 1'b0;
    m_inst = 32'd0;
    m_ipc = 32'd0;
    mem_pend = 1'b0;
  endtask

  function automatic bit exp_req();
    return m_started && !m_halted && !m_outstanding && !m_have;
  endfunction

  task automatic model_update();
    logic [31:0] tgt;
    tgt = redirect_pc & 32'hFFFF_FFFC;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!m_halted) begin
      if (m_outstanding) begin
        if (redirect_valid) m_pc = tgt;
        if (imem_rsp_valid) begin
          m_outstanding = 1'b0;
          if (m_drop || redirect_valid) begin
            m_drop = 1'b0;
          end else begin
            m_have = 1'b1;
            m_inst = imem_rsp_data;
            m_ipc  = m_pc;
          end
        end else if (redirect_valid) begin
          m_drop = 1'b1;
        end
      end else if (m_have) begin
        if (inst_ready) begin
          m_have = 1'b0;
          m_pc = redirect_valid ? tgt : m_pc + 32'd4;
          if (halt) m_halted = 1'b1;
        end else if (redirect_valid) begin
          m_have = 1'b0;
          m_pc = tgt;
        end
      end else begin
        if (halt) begin
          m_halted = 1'b1;
        end else begin
          if (redirect_valid) m_pc = tgt;
          if (imem_req_ready) begin
            m_outstanding = 1'b1;
            m_drop = redirect_valid;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req()});
    chk("req_addr", imem_req_addr, exp_req() ? m_pc : 32'd0);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_have});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic cycle();
    bit acc;
    if (auto_mem) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = mem_pend;
      imem_rsp_data  = auto_data;
    end
    acc = exp_req() && imem_req_ready;
    @(posedge clk);
    model_update();
    mem_pend = auto_mem && acc;
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Zero-wait memory, first fetch from reset PC.
    auto_mem = 1'b1;
    cycle();
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    cycle();
    cycle();
    chk("first_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("first_inst_pc", inst_pc, 32'h8000_0000);
    chk("first_inst", inst, 32'h0000_0013);

    // Decode backpressure for five cycles.
    repeat (5) cycle();
    chk("bp_inst_pc", inst_pc, 32'h8000_0000);
    chk("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    chk("seq_next_addr", imem_req_addr, 32'h8000_0004);

    // Redirect while waiting: response dropped, target word-aligned.
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0103;
    cycle();
    redirect_valid = 1'b0;
    chk("squash_no_inst", {31'd0, inst_valid}, 32'd0);
    chk("squash_addr", imem_req_addr, 32'h8000_0100);

    // Redirect coincident with consumption.
    cycle();
    cycle();
    chk("redir_inst_pc", inst_pc, 32'h8000_0100);
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0040;
    cycle();
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("redir_issue_addr", imem_req_addr, 32'h8000_0040);

    // PC wrap at the top of the address space.
    cycle();
    cycle();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    cycle();
    cycle();
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Reset in the middle of a wait; the late response must be ignored.
    cycle();
    do_reset();
    auto_mem = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    cycle();
    imem_rsp_valid = 1'b0;
    chk("late_rsp_ignored", {31'd0, inst_valid}, 32'd0);
    chk("restart_addr", imem_req_addr, 32'h8000_0000);

    // Halt on the issue handshake.
    auto_mem = 1'b1;
    cycle();
    cycle();
    inst_ready = 1'b1;
    halt = 1'b1;
    cycle();
    inst_ready = 1'b0;
    halt = 1'b0;
    repeat (20) cycle();
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
    do_reset();
    cycle();
    chk("halt_restart", imem_req_addr, 32'h8000_0000);

    // Randomized traffic.
    auto_mem = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 1) == 0);
      imem_rsp_valid = ($urandom_range(0, 4) < 2);
      imem_rsp_data  = $urandom;
      inst_ready     = ($urandom_range(0, 1) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else redirect_pc = $urandom;
      halt = ($urandom_range(0, 49) == 0);
      if (i % 150 == 149) do_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
